// File: rtl/ibus_pkg.sv
// Shared IBus definitions for the 16-bit parallel memory responder.
// Holds bus widths and the fetch state encoding.
package ibus_pkg;

   localparam int IBUS_ADDR_W = 30;
   localparam int IBUS_DATA_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LO,
      ST_HI,
      ST_DONE
   } state_t;

endpackage

// File: rtl/ibus_mem16_seq.sv
// Half-word access sequencer: access-time counter, chip/output
// enable sequencing, half-word address LSB and capture strobes.
module ibus_mem16_seq
   import ibus_pkg::*;
#(
   parameter int ACCESS_CYCLES = 3
) (
   input  logic   i_Clk,
   input  logic   i_Rst_n,
   input  state_t i_State,
   input  logic   i_Start,
   input  logic   i_Abort,
   output logic   o_Cap_Lo,
   output logic   o_Cap_Hi,
   output logic   o_Mem_CE_n,
   output logic   o_Mem_OE_n,
   output logic   o_Addr_Lsb
);

   localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(ACCESS_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          en_n_q, en_n_d;
   logic          lsb_q, lsb_d;
   logic          active;
   logic          last;

   // Strobe on the final cycle of each half-word access.
   always_comb begin
      active   = (i_State == ST_LO) || (i_State == ST_HI);
      last     = active && (cnt_q == CNT_LAST);
      o_Cap_Lo = last && (i_State == ST_LO);
      o_Cap_Hi = last && (i_State == ST_HI);
   end

   // Next counter, enable and LSB; abort wins over everything.
   always_comb begin
      cnt_d  = cnt_q;
      en_n_d = en_n_q;
      lsb_d  = lsb_q;
      if (i_Abort) begin
         cnt_d  = '0;
         en_n_d = 1'b1;
      end else if (i_Start) begin
         cnt_d  = '0;
         en_n_d = 1'b0;
         lsb_d  = 1'b0;
      end else if (active) begin
         if (last) begin
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
         if (o_Cap_Lo) begin
            lsb_d = 1'b1;
         end
         if (o_Cap_Hi) begin
            en_n_d = 1'b1;
         end
      end
   end

   // Sequencer registers; enables idle deasserted.
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         cnt_q  <= '0;
         en_n_q <= 1'b1;
         lsb_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         en_n_q <= en_n_d;
         lsb_q  <= lsb_d;
      end
   end

   assign o_Mem_CE_n = en_n_q;
   assign o_Mem_OE_n = en_n_q;
   assign o_Addr_Lsb = lsb_q;

endmodule

// File: rtl/ibus_mem16_slave.sv
// IBus responder serving 32-bit fetches from a 16-bit async memory.
// Optional next-word prefetch buffer: define IBUS_MEM16_PREFETCH_EN.
module ibus_mem16_slave
   import ibus_pkg::*;
#(
   parameter int ACCESS_CYCLES = 3,
   parameter int MEM_ADDR_W    = 20
) (
   input  logic                   i_Clk,
   input  logic                   i_Rst_n,
   input  logic [IBUS_ADDR_W-1:0] i_IBus_Address,
   input  logic                   i_IBus_Read,
   output logic [IBUS_DATA_W-1:0] o_IBus_ReadData,
   output logic                   o_IBus_WaitReq,
   output logic [MEM_ADDR_W-1:0]  o_Mem_Addr,
   output logic                   o_Mem_CE_n,
   output logic                   o_Mem_OE_n,
   input  logic [15:0]            i_Mem_Data
);

   state_t                 state_q, state_d;
   logic [IBUS_ADDR_W-1:0] addr_q, addr_d;
   logic [IBUS_DATA_W-1:0] rdata_q, rdata_d;
   logic [IBUS_DATA_W-1:0] word_q, word_d;
   logic                   start;
   logic                   abort;
   logic                   waitreq;
   logic                   cap_lo;
   logic                   cap_hi;
   logic                   addr_lsb;
   logic                   unused_addr;

`ifdef IBUS_MEM16_PREFETCH_EN
   logic pf_q, pf_d;
   logic vld_q, vld_d;
   logic hit;
`endif

   ibus_mem16_seq #(
      .ACCESS_CYCLES(ACCESS_CYCLES)
   ) u_seq (
      .i_Clk      (i_Clk),
      .i_Rst_n    (i_Rst_n),
      .i_State    (state_q),
      .i_Start    (start),
      .i_Abort    (abort),
      .o_Cap_Lo   (cap_lo),
      .o_Cap_Hi   (cap_hi),
      .o_Mem_CE_n (o_Mem_CE_n),
      .o_Mem_OE_n (o_Mem_OE_n),
      .o_Addr_Lsb (addr_lsb)
   );

   // Handshake FSM, word assembly and prefetch bookkeeping.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rdata_d = rdata_q;
      word_d  = word_q;
      start   = 1'b0;
      abort   = 1'b0;
      waitreq = 1'b1;
`ifdef IBUS_MEM16_PREFETCH_EN
      pf_d  = pf_q;
      vld_d = vld_q;
      hit   = vld_q && (i_IBus_Address == addr_q);
`endif
      if (cap_lo) begin
         word_d[15:0] = i_Mem_Data;
      end
      if (cap_hi) begin
         word_d[31:16] = i_Mem_Data;
      end
      unique case (state_q)
         ST_IDLE: begin
`ifdef IBUS_MEM16_PREFETCH_EN
            if (i_IBus_Read && hit) begin
               waitreq = 1'b0;
               rdata_d = word_q;
               addr_d  = addr_q + 1'b1;
               vld_d   = 1'b0;
               pf_d    = 1'b1;
               start   = 1'b1;
               state_d = ST_LO;
            end else if (i_IBus_Read) begin
               addr_d  = i_IBus_Address;
               vld_d   = 1'b0;
               pf_d    = 1'b0;
               start   = 1'b1;
               state_d = ST_LO;
            end
`else
            if (i_IBus_Read) begin
               addr_d  = i_IBus_Address;
               start   = 1'b1;
               state_d = ST_LO;
            end
`endif
         end
         ST_LO, ST_HI: begin
`ifdef IBUS_MEM16_PREFETCH_EN
            if (pf_q && i_IBus_Read &&
                (i_IBus_Address != addr_q)) begin
               abort   = 1'b1;
               pf_d    = 1'b0;
               vld_d   = 1'b0;
               state_d = ST_IDLE;
            end else if (!pf_q && !i_IBus_Read) begin
               abort   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               // A matching demand turns the prefetch into the fetch.
               if (i_IBus_Read) begin
                  pf_d = 1'b0;
               end
               if (cap_lo) begin
                  state_d = ST_HI;
               end
               if (cap_hi) begin
                  if (pf_d) begin
                     pf_d    = 1'b0;
                     vld_d   = 1'b1;
                     state_d = ST_IDLE;
                  end else begin
                     state_d = ST_DONE;
                  end
               end
            end
`else
            if (!i_IBus_Read) begin
               abort   = 1'b1;
               state_d = ST_IDLE;
            end else if (cap_lo) begin
               state_d = ST_HI;
            end else if (cap_hi) begin
               state_d = ST_DONE;
            end
`endif
         end
         ST_DONE: begin
            waitreq = 1'b0;
            state_d = ST_IDLE;
            if (i_IBus_Read) begin
               rdata_d = word_q;
`ifdef IBUS_MEM16_PREFETCH_EN
               addr_d  = addr_q + 1'b1;
               pf_d    = 1'b1;
               start   = 1'b1;
               state_d = ST_LO;
`endif
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Handshake registers; partial word is dropped on reset.
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         rdata_q <= '0;
         word_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rdata_q <= rdata_d;
         word_q  <= word_d;
      end
   end

`ifdef IBUS_MEM16_PREFETCH_EN
   // Prefetch flags; the buffer word and tag reuse word_q/addr_q.
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         pf_q  <= 1'b0;
         vld_q <= 1'b0;
      end else begin
         pf_q  <= pf_d;
         vld_q <= vld_d;
      end
   end
`endif

   // Upper word-address bits alias in memory.
   assign unused_addr     = ^addr_q;
   assign o_Mem_Addr      = {addr_q[MEM_ADDR_W-2:0], addr_lsb};
   assign o_IBus_ReadData = rdata_q;
   assign o_IBus_WaitReq  = waitreq;

endmodule

// File: doc/ibus_mem16_slave.md
# ibus_mem16_slave

IBus responder that serves 32-bit instruction fetches from an external 16-bit asynchronous parallel memory (NOR flash or SRAM). Each IBus word read becomes two half-word accesses with a programmable access time. `o_IBus_WaitReq` is held high until the word is assembled. The block sits on the instruction bus opposite the CPU's IBus master, as the boot/program memory target.

## Interface
Parameters:
- ACCESS_CYCLES, 3, clock cycles per half-word access (≥1)
- MEM_ADDR_W, 20, external half-word address width (2..31)

Ports:
- i_Clk  in  1  system clock; all logic on rising edge
- i_Rst_n  in  1  reset, asynchronous assert, active-low
- i_IBus_Address  in  30  word address; must be stable while Read=1 and WaitReq=1
- i_IBus_Read  in  1  read request
- o_IBus_ReadData  out  32  read data, registered
- o_IBus_WaitReq  out  1  high = transfer not accepted this cycle
- o_Mem_Addr  out  MEM_ADDR_W  half-word address, registered
- o_Mem_CE_n  out  1  chip enable, active-low, registered
- o_Mem_OE_n  out  1  output enable, active-low, registered
- i_Mem_Data  in  16  memory data bus

## Operation
- Reset values: ReadData=0, WaitReq=1, Mem_Addr=0, CE_n=1, OE_n=1, state IDLE.
- States: IDLE, LO, HI, DONE.
- IDLE, Read=1:
  - Latch address.
  - Mem_Addr={addr[MEM_ADDR_W-2:0],1'b0}; CE_n=OE_n=0.
  - Go to LO.
- LO:
  - Counts ACCESS_CYCLES cycles.
  - Last edge captures i_Mem_Data into the low half of the word (bits 15:0).
  - Mem_Addr LSB becomes 1; go to HI.
- HI:
  - Same count.
  - Last edge captures bits 31:16; CE_n=OE_n=1; go to DONE.
- DONE:
  - WaitReq=0. The edge with Read=1 is the acceptance edge.
  - Assembled word is loaded into ReadData; go to IDLE.
- WaitReq is combinational: 0 only in DONE (or on a prefetch hit, see Configuration). It is 1 in every other state, including IDLE.
- ReadData holds its last value until the next acceptance.
- Read drops during LO/HI/DONE: abort at the next edge. CE_n/OE_n return to 1, state goes to IDLE, ReadData is unchanged.
- Back-to-back: Read held high after an acceptance with a new address. The next cycle is IDLE with WaitReq=1 and a new fetch starts.
- Address bits above MEM_ADDR_W-2 are ignored (memory aliases).
- Reset asserted mid-access: all outputs go immediately to their reset values and the partial word is discarded.

## Timing
- Read-to-accept latency (N=ACCESS_CYCLES):
  - WaitReq is high for 2N+1 cycles from the cycle Read rises (cycle 0).
  - DONE is cycle 2N+1; acceptance is at the end of DONE.
  - ReadData is valid from cycle 2N+2.
- For N=3: accept at end of cycle 7; data valid from cycle 8.
- Read data latency is 1 cycle after the acceptance edge, matching the master's registered-enable capture.
- Memory data is sampled N cycles after Mem_Addr/OE_n change. The external access time must be less than N clock periods minus I/O delay.

## Configuration
- IBUS_MEM16_PREFETCH_EN defined:
  - After each acceptance at address A, the block fetches A+1 into a one-word buffer with tag and valid bit. Address A+1 wraps at 2^30.
  - Read in IDLE with a matching valid tag is a hit: WaitReq=0 in the same cycle, and ReadData loads the buffer at the acceptance edge. The next prefetch (A+2) then starts.
  - Read matching an in-flight prefetch waits for it to finish, then enters DONE.
  - Read with a non-matching address aborts the prefetch, clears valid, and starts a demand fetch next cycle.
  - Reset clears valid.
- Undefined: no buffer; after acceptance the block stays in IDLE with CE_n=1.

## Structure
- Package ibus_pkg holds:
  - IBUS_ADDR_W=30 and IBUS_DATA_W=32.
  - The state enum ST_IDLE/ST_LO/ST_HI/ST_DONE.
- Sub-module ibus_mem16_seq is the half-word access sequencer: cycle counter, CE_n/OE_n/Mem_Addr LSB sequencing, and the capture strobes. ibus_mem16_slave owns the IBus handshake, data assembly and the prefetch buffer.

## Test plan
- Single read, N=3, memory model returns 0x1234 at half-address 0x00010 and 0xABCD at 0x00011; Read at Address=0x8 → WaitReq high 7 cycles, accept at cycle 7, ReadData=0xABCD1234 from cycle 8.
- N=1, back-to-back reads at 0x0, 0x1, Read held high → each word takes 3 cycles of WaitReq and one acceptance; data is correct and in order.
- Read dropped in HI → CE_n=OE_n=1 next cycle, ReadData unchanged; a following read at another address returns that address's correct data.
- i_Rst_n pulsed low in LO → WaitReq=1, CE_n=1, ReadData=0 immediately; a fresh read after release completes normally.
- Address 0x3FFFFFFF with MEM_ADDR_W=20 → Mem_Addr=0xFFFFE, then 0xFFFFF.
- Prefetch build: read 0x10, then read 0x11 after the prefetch completes → second read has WaitReq=0 in its first cycle. A later read at 0x40 aborts the pending 0x12 prefetch and returns the correct data.
